// File: rtl/mvm_stream_arbiter.sv
// rtl/mvm_stream_arbiter.sv - round-robin whole-transaction arbiter sharing one layer engine between two requesters
`timescale 1ns/1ps

module mvm_stream_arbiter #(
  parameter int N     = 8,
  parameter int M     = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s0_valid,
  output logic             s0_ready,
  input  logic [WIDTH-1:0] s0_data,
  output logic             m0_valid,
  input  logic             m0_ready,
  output logic [WIDTH-1:0] m0_data,
  input  logic             s1_valid,
  output logic             s1_ready,
  input  logic [WIDTH-1:0] s1_data,
  output logic             m1_valid,
  input  logic             m1_ready,
  output logic [WIDTH-1:0] m1_data,
  output logic             e_s_valid,
  input  logic             e_s_ready,
  output logic [WIDTH-1:0] e_s_data,
  input  logic             e_m_valid,
  output logic             e_m_ready,
  input  logic [WIDTH-1:0] e_m_data,
  output logic             owner,
  output logic             busy
);

  localparam int ICW = $clog2(N + 1);
  localparam int OCW = $clog2(M + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FWD_IN  = 2'd1,
    FWD_OUT = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic           owner_nxt;
  logic           last, last_nxt;
  logic [ICW-1:0] in_cnt, in_cnt_nxt;
  logic [OCW-1:0] out_cnt, out_cnt_nxt;
  logic           in_xfer, out_xfer;

  // State, grant and element counters; async reset discards any partial transaction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      last    <= last_nxt;
      in_cnt  <= in_cnt_nxt;
      out_cnt <= out_cnt_nxt;
    end
  end

  // Arbitration, stream routing to/from the owner, and transaction sequencing
  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    last_nxt    = last;
    in_cnt_nxt  = in_cnt;
    out_cnt_nxt = out_cnt;
    s0_ready    = 1'b0;
    s1_ready    = 1'b0;
    m0_valid    = 1'b0;
    m1_valid    = 1'b0;
    m0_data     = '0;
    m1_data     = '0;
    e_s_valid   = 1'b0;
    e_s_data    = '0;
    e_m_ready   = 1'b0;
    in_xfer     = 1'b0;
    out_xfer    = 1'b0;

    unique case (state)
      IDLE: begin
        // Contention goes to whoever did not finish last; a lone request wins outright
        if (s0_valid || s1_valid) begin
          owner_nxt  = (s0_valid && s1_valid) ? ~last : s1_valid;
          in_cnt_nxt = '0;
          state_nxt  = FWD_IN;
        end
      end

      FWD_IN: begin
        // Ready comes only from the engine and registered owner, never from sX_valid
        e_s_valid = owner ? s1_valid : s0_valid;
        e_s_data  = owner ? s1_data  : s0_data;
        if (owner) s1_ready = e_s_ready;
        else       s0_ready = e_s_ready;
        in_xfer = (owner ? s1_valid : s0_valid) && e_s_ready;
        if (in_xfer) begin
          in_cnt_nxt = in_cnt + ICW'(1);
          if (in_cnt == ICW'(N - 1)) begin
            out_cnt_nxt = '0;
            state_nxt   = FWD_OUT;
          end
        end
      end

      FWD_OUT: begin
        if (owner) begin
          m1_valid  = e_m_valid;
          m1_data   = e_m_data;
          e_m_ready = m1_ready;
        end else begin
          m0_valid  = e_m_valid;
          m0_data   = e_m_data;
          e_m_ready = m0_ready;
        end
        out_xfer = e_m_valid && (owner ? m1_ready : m0_ready);
        if (out_xfer) begin
          out_cnt_nxt = out_cnt + OCW'(1);
          if (out_cnt == OCW'(M - 1)) begin
            last_nxt  = owner;
            state_nxt = IDLE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mvm_stream_arbiter.sv
// tb/tb_mvm_stream_arbiter.sv - scoreboard bench for mvm_stream_arbiter with a behavioural engine model
`timescale 1ns/1ps

module tb_mvm_stream_arbiter;

  localparam int N = 8;
  localparam int M = 8;
  localparam int W = 8;

  typedef logic [W-1:0] vec_t [N];

  logic         clk = 1'b0;
  logic         reset;
  logic         s_valid [2];
  logic         s_ready [2];
  logic [W-1:0] s_data  [2];
  logic         m_valid [2];
  logic         m_ready [2];
  logic [W-1:0] m_data  [2];
  logic         e_s_valid, e_s_ready, e_m_valid, e_m_ready;
  logic [W-1:0] e_s_data, e_m_data;
  logic         owner, busy;

  int           n_checks = 0;
  int           n_pass   = 0;
  logic [W-1:0] exp0[$];
  logic [W-1:0] exp1[$];
  int           rcv [2];
  int           rdy_mode [2];
  logic         eng_rdy_rand;
  logic         early;
  int           grant_log[$];

  mvm_stream_arbiter #(.N(N), .M(M), .WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .s0_valid(s_valid[0]), .s0_ready(s_ready[0]), .s0_data(s_data[0]),
    .m0_valid(m_valid[0]), .m0_ready(m_ready[0]), .m0_data(m_data[0]),
    .s1_valid(s_valid[1]), .s1_ready(s_ready[1]), .s1_data(s_data[1]),
    .m1_valid(m_valid[1]), .m1_ready(m_ready[1]), .m1_data(m_data[1]),
    .e_s_valid(e_s_valid), .e_s_ready(e_s_ready), .e_s_data(e_s_data),
    .e_m_valid(e_m_valid), .e_m_ready(e_m_ready), .e_m_data(e_m_data),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    $display("FAIL %s: actual timeout required completion", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The engine adds 9 to each element, so a requester must get back its own elements plus 9, in order
  function automatic logic [W-1:0] ref_result(input logic [W-1:0] x);
    return x + 8'd9;
  endfunction

  task automatic rand_vec(output vec_t v);
    foreach (v[i]) v[i] = 8'($urandom);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_handshake"}, {s_ready[0], s_ready[1], m_valid[0], m_valid[1],
                              e_s_valid, e_m_ready, busy, owner}, 0);
    chk({tag, "_data"}, {m_data[0], m_data[1], e_s_data}, 0);
  endtask

  // Issue one N-element transaction from requester id; optional valid drop after element stall_after
  task automatic send_txn(input int id, input vec_t d, input int stall_after, input int stall_len);
    int   i, stall, guard;
    logic acc;
    foreach (d[j]) begin
      if (id == 0) exp0.push_back(ref_result(d[j]));
      else         exp1.push_back(ref_result(d[j]));
    end
    i = 0; stall = 0; guard = 0;
    s_valid[id] = 1'b1;
    s_data[id]  = d[0];
    while (i < N) begin
      @(negedge clk);
      acc = s_valid[id] && s_ready[id];
      tick();
      if (acc) begin
        i++;
        if (i == stall_after) stall = stall_len;
      end
      if (i == N) begin
        s_valid[id] = 1'b0;
        s_data[id]  = '0;
      end else if (stall > 0) begin
        s_valid[id] = 1'b0;
        stall--;
      end else begin
        s_valid[id] = 1'b1;
        s_data[id]  = d[i];
      end
      guard++;
      if (guard > 3000) begin
        fail_timeout($sformatf("s%0d_send", id));
        s_valid[id] = 1'b0;
        break;
      end
    end
  endtask

  // Consumer side: random/patterned ready, pop scoreboard on every accepted result
  task automatic consumer(input int id);
    int           cyc;
    logic [W-1:0] e;
    logic         empty;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (m_valid[id] && m_ready[id]) begin
        empty = (id == 0) ? (exp0.size() == 0) : (exp1.size() == 0);
        if (empty) begin
          n_checks++;
          $display("FAIL m%0d_unexpected: actual data %0h required no transfer", id, m_data[id]);
        end else begin
          e = (id == 0) ? exp0.pop_front() : exp1.pop_front();
          chk($sformatf("m%0d_data", id), m_data[id], e);
        end
        rcv[id]++;
      end
      tick();
      cyc++;
      case (rdy_mode[id])
        0:       m_ready[id] = 1'b1;
        1:       m_ready[id] = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: m_ready[id] = ($urandom_range(0, 3) != 0);
      endcase
    end
  endtask

  task automatic wait_idle(input string name);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while ((busy || exp0.size() != 0 || exp1.size() != 0) && g < 3000);
    if (g >= 3000) fail_timeout(name);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  // Behavioural engine: collect N inputs, then present M results; optional early e_m_valid
  initial begin : engine
    int   cnt, oj;
    bit   outp;
    vec_t ebuf;
    cnt = 0; oj = 0; outp = 1'b0;
    foreach (ebuf[i]) ebuf[i] = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cnt = 0; oj = 0; outp = 1'b0;
      end else if (!outp) begin
        if (early && e_m_valid) begin
          chk("early_e_m_ready", e_m_ready, 0);
          chk("early_m_valid", {m_valid[0], m_valid[1]}, 0);
        end
        if (e_s_valid && e_s_ready) begin
          ebuf[cnt] = e_s_data;
          cnt++;
          if (cnt == N) begin
            outp = 1'b1;
            oj   = 0;
          end
        end
      end else if (e_m_valid && e_m_ready) begin
        oj++;
        if (oj == M) begin
          outp = 1'b0;
          cnt  = 0;
        end
      end
      tick();
      if (outp) begin
        e_s_ready = 1'b0;
        e_m_valid = 1'b1;
        e_m_data  = ebuf[oj] + 8'd9;
      end else begin
        e_s_ready = eng_rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        e_m_valid = early;
        e_m_data  = early ? 8'hEE : 8'h00;
      end
    end
  end

  initial begin : consumers
    fork
      consumer(0);
      consumer(1);
    join
  end

  // Record the owner at each start of a transaction
  initial begin : grant_logger
    bit prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (busy && !prev_busy) grant_log.push_back(int'(owner));
      prev_busy = busy;
    end
  end

  initial begin : main
    vec_t d, d2;
    int   g, seen, base;
    logic viol;

    reset = 1'b1;
    s_valid[0] = 1'b1; s_valid[1] = 1'b1;
    s_data[0] = 8'h55; s_data[1] = 8'hAA;
    m_ready[0] = 1'b1; m_ready[1] = 1'b1;
    rdy_mode[0] = 0; rdy_mode[1] = 0;
    rcv[0] = 0; rcv[1] = 0;
    eng_rdy_rand = 1'b0; early = 1'b0;
    e_s_ready = 1'b0; e_m_valid = 1'b0; e_m_data = '0;

    #2;
    chk_all_zero("rst_t0");
    repeat (3) tick();
    chk_all_zero("rst_hold");
    s_valid[0] = 1'b0; s_valid[1] = 1'b0;
    s_data[0] = '0; s_data[1] = '0;
    tick();
    reset = 1'b0;
    tick();
    chk_all_zero("idle_after_rst");

    // Single requester: 1..8 in, 10..17 back, busy drops one cycle after the last output
    foreach (d[i]) d[i] = 8'(i + 1);
    grant_log.delete();
    fork
      send_txn(0, d, -1, 0);
      begin
        seen = 0; g = 0; viol = 1'b0;
        while (seen < M && g < 500) begin
          @(negedge clk);
          g++;
          if (s_ready[1] || m_valid[1]) viol = 1'b1;
          if (m_valid[0] && m_ready[0]) seen++;
        end
        if (seen < M) fail_timeout("t1_outputs");
        else begin
          chk("t1_busy_at_last_out", busy, 1);
          @(negedge clk);
          chk("t1_busy_after_last_out", busy, 0);
        end
        chk("t1_s1_m1_quiet", viol, 0);
      end
    join
    wait_idle("t1_idle");
    chk("t1_grant", (grant_log.size() == 1) ? grant_log[0] : 99, 0);

    // Dual requests after reset alternate 0,1,0,1
    do_reset();
    grant_log.delete();
    for (int r = 0; r < 2; r++) begin
      rand_vec(d); rand_vec(d2);
      fork
        send_txn(0, d, -1, 0);
        send_txn(1, d2, -1, 0);
      join
      wait_idle("t2_idle");
    end
    chk("t2_grant_count", grant_log.size(), 4);
    for (int i = 0; i < grant_log.size() && i < 4; i++)
      chk($sformatf("t2_grant%0d", i), grant_log[i], i % 2);

    // s1 requests during s0's output phase: blocked until s0's last output, granted next cycle
    rand_vec(d); rand_vec(d2);
    fork
      send_txn(0, d, -1, 0);
      begin
        g = 0;
        do begin
          @(negedge clk);
          g++;
        end while (!m_valid[0] && g < 500);
        seen = (m_valid[0] && m_ready[0]) ? 1 : 0;
        tick();
        fork
          send_txn(1, d2, -1, 0);
          begin
            viol = 1'b0; g = 0;
            while (seen < M && g < 500) begin
              @(negedge clk);
              g++;
              if (s_ready[1]) viol = 1'b1;
              if (m_valid[0] && m_ready[0]) seen++;
            end
            chk("t3_s1_blocked", viol, 0);
            if (seen < M) fail_timeout("t3_s0_outputs");
            else begin
              @(negedge clk);
              chk("t3_arb_cycle", {busy, s_ready[1]}, 2'b00);
              @(negedge clk);
              chk("t3_s1_granted", {busy, owner, s_ready[1]}, 3'b111);
            end
          end
        join
      end
    join
    wait_idle("t3_idle");

    // Backpressure 1,0,0,1 on m0 and a 3-cycle valid drop after element 4
    rdy_mode[0] = 1;
    base = rcv[0];
    rand_vec(d);
    send_txn(0, d, 4, 3);
    wait_idle("t4_idle");
    chk("t4_out_count", rcv[0] - base, M);
    rdy_mode[0] = 0;

    // Engine asserts e_m_valid while inputs are still being forwarded
    early = 1'b1; eng_rdy_rand = 1'b1;
    rand_vec(d);
    send_txn(1, d, -1, 0);
    wait_idle("t5_idle");
    early = 1'b0; eng_rdy_rand = 1'b0;

    // Reset after five inputs from s1, then a dual request must go to s0
    s_valid[1] = 1'b1;
    s_data[1]  = 8'($urandom);
    seen = 0; g = 0;
    while (seen < 5 && g < 200) begin
      @(negedge clk);
      if (s_valid[1] && s_ready[1]) seen++;
      tick();
      s_data[1] = 8'($urandom);
      g++;
    end
    if (seen < 5) fail_timeout("t6_five_inputs");
    chk("t6_owner_before_rst", {busy, owner}, 2'b11);
    reset = 1'b1;
    #1;
    chk_all_zero("t6_rst");
    s_valid[1] = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    grant_log.delete();
    rand_vec(d); rand_vec(d2);
    fork
      send_txn(0, d, -1, 0);
      send_txn(1, d2, -1, 0);
    join
    wait_idle("t6_idle");
    chk("t6_grant_count", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      chk("t6_first_grant", grant_log[0], 0);
      chk("t6_second_grant", grant_log[1], 1);
    end

    // Randomized mix of readiness, stalls and request timing
    for (int r = 0; r < 10; r++) begin
      rdy_mode[0]  = $urandom_range(0, 2);
      rdy_mode[1]  = $urandom_range(0, 2);
      eng_rdy_rand = $urandom_range(0, 1);
      early        = $urandom_range(0, 1);
      rand_vec(d); rand_vec(d2);
      fork
        send_txn(0, d, $urandom_range(1, 7), $urandom_range(0, 3));
        begin
          repeat ($urandom_range(0, 12)) tick();
          send_txn(1, d2, $urandom_range(1, 7), $urandom_range(0, 3));
        end
      join
      wait_idle($sformatf("rand%0d_idle", r));
    end
    early = 1'b0;

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mvm_stream_arbiter.md
Name: mvm_stream_arbiter

Overview:
- Shares one layer engine (an 8x8 matrix-vector layer with ReLU and a valid/ready stream interface) between two independent requesters.
- Grants the engine for one whole transaction: N input elements in, then M results back to the same requester.
- Transactions are never interleaved. Grants alternate round-robin between the requesters.
- Sits between the two producer/consumer pairs and a single layer instance in the network top level.

Parameters:
N, 8, input elements per transaction
M, 8, output elements per transaction
WIDTH, 8, data width in bits (signed)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
s0_valid  input  1  requester 0 input element valid
s0_ready  output  1  requester 0 input element accepted
s0_data  input  WIDTH  requester 0 input element
m0_valid  output  1  result valid to requester 0
m0_ready  input  1  requester 0 ready for result
m0_data  output  WIDTH  result to requester 0
s1_valid, s1_ready, s1_data, m1_valid, m1_ready, m1_data  same as port 0, for requester 1
e_s_valid  output  1  input element valid to engine
e_s_ready  input  1  engine accepts input element
e_s_data  output  WIDTH  input element to engine
e_m_valid  input  1  engine result valid
e_m_ready  output  1  ready for engine result
e_m_data  input  WIDTH  engine result
owner  output  1  index of the current/last granted requester
busy  output  1  high whenever state is not IDLE

Behaviour:
- States: IDLE, FWD_IN, FWD_OUT.
- Registers: state, owner, in_cnt and out_cnt (width $clog2(N+1) and $clog2(M+1)), last.
- Reset values:
  - state=IDLE, owner=0, last=1 (requester 0 wins first), counters=0.
  - All valid/ready outputs are 0 and all data outputs are 0 while reset is asserted and in IDLE.
- IDLE:
  - No transfers; all handshake outputs are low.
  - If exactly one sX_valid is high, grant X.
  - If both are high, grant !last.
  - On grant: owner<=X, in_cnt<=0, state<=FWD_IN. This costs one arbitration cycle.
- FWD_IN (combinational routing):
  - e_s_valid = s[owner]_valid; e_s_data = s[owner]_data; s[owner]_ready = e_s_ready.
  - The non-owner s_ready is 0.
  - An element transfers when e_s_valid && e_s_ready; in_cnt increments.
  - On the N-th transfer: out_cnt<=0, state<=FWD_OUT.
  - e_m_ready=0 in this state. Any e_m_valid from the engine waits.
- FWD_OUT (combinational routing):
  - m[owner]_valid = e_m_valid; m[owner]_data = e_m_data; e_m_ready = m[owner]_ready.
  - The non-owner m_valid is 0 and its m_data is 0.
  - A transfer increments out_cnt.
  - On the M-th transfer: last<=owner, state<=IDLE.
  - e_s_valid=0 in this state, and both s_ready are 0.
- No combinational path from any sX_valid to sX_ready. Ready depends only on e_s_ready and registered owner/state.
- Requester stalls:
  - A valid drop mid-transaction stalls without losing count.
  - The other requester stays blocked until the transaction completes.
- Simultaneous events:
  - A requester asserting valid in the same cycle that the other's transaction returns to IDLE is considered in the next IDLE cycle.
  - The returning requester is then lower priority if both request.
- Backpressure: m[owner]_ready low holds the engine result. The arbiter never drops or duplicates elements.
- Async reset mid-transaction: returns to IDLE immediately and clears counters. The engine must share this reset; partial transactions are discarded.
- busy = (state != IDLE). owner holds its value in IDLE.
- Data is passed unmodified, with no width conversion or sign handling.

Test Plan:
- Single requester: s0 sends 1..8 with e_s_ready=1, engine returns 8 results 10..17 with m0_ready=1 -> engine sees 1..8 in order. m0 receives 10..17. m1_valid and s1_ready stay 0. busy drops 1 cycle after the 8th output.
- Both request at the first post-reset IDLE -> owner=0 first. After its 8 outputs complete, owner=1 is granted. A third back-to-back request goes to 0 again (alternation).
- s1 asserts valid during s0's FWD_OUT phase -> s1_ready stays 0 until s0's 8th output transfers. s1 is then granted one cycle later.
- Backpressure: m0_ready toggles 1,0,0,1 through all outputs. s0_valid is dropped for 3 cycles after element 4 -> exactly 8 elements in and 8 out, each delivered once and in order.
- Engine e_m_valid asserted during FWD_IN -> e_m_ready=0 and no m0/m1 transfer until the state is FWD_OUT.
- Assert reset after 5 inputs from s1 -> all outputs 0 within the same cycle. After release, IDLE with last=1, so a dual request grants s0.
